led_arbiter: RTL and testbench

Shares the board's single status LED among N_REQ independent requesters. It grants the LED to one requester at a time using round-robin arbitration and renders that requester's selected pattern: off, solid, slow blink or fast blink. It inserts an off-gap between owners and, optionally, rotates ownership after a hold time. It sits between the design's status sources and the LED pin, clocked from the board's 12 MHz clock after the power-up reset generator.

---
 rtl/led_arbiter.sv | 169 ++++++++++++++++
 tb/tb_led_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// Round-robin owner of the single status LED: grants one requester at a time, renders its pattern,
// forces an off-gap between owners. Define LED_ARB_PREEMPT_EN to rotate ownership after HOLD_TICKS.
module led_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 12000,
  parameter int SLOW_HALF  = 250,
  parameter int FAST_HALF  = 62,
  parameter int GAP_TICKS  = 100,
  parameter int HOLD_TICKS = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] mode,
  output logic [N_REQ-1:0]   grant,
  output logic               led,
  output logic [1:0]         state_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(TICK_DIV) + 1;
  localparam int PW = $clog2((SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF) + 1;
  localparam int GW = $clog2(GAP_TICKS) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [DW-1:0]    div_q;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             level_q, level_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             led_q, led_d;
  logic [IW-1:0]    pick_idx;
  logic [PW-1:0]    half;
  logic [PW-1:0]    phase_inc;
  logic             leave_serve;
  int               rr_idx;

`ifdef LED_ARB_PREEMPT_EN
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          other_req;
  assign other_req = |(req & ~grant_q);
`endif

  assign tick      = (div_q == DW'(TICK_DIV - 1));
  assign half      = mode_q[0] ? PW'(FAST_HALF) : PW'(SLOW_HALF);
  assign phase_inc = phase_q + PW'(1);
  assign grant     = grant_q;
  assign led       = led_q;
  assign state_o   = state_q;

  // Scan from ptr+1 upward; iterating downward lets the nearest set request win last.
  always_comb begin
    pick_idx = '0;
    rr_idx   = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      rr_idx = (int'(ptr_q) + i) % N_REQ;
      if (req[IW'(rr_idx)]) pick_idx = IW'(rr_idx);
    end
  end

  // req is a level: grant rises one cycle after a request is seen in IDLE and
  // falls one cycle after the owner's req drops; no other acknowledge exists.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    level_d     = level_q;
    gap_d       = gap_q;
    leave_serve = 1'b0;
`ifdef LED_ARB_PREEMPT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_SERVE;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          mode_d  = mode[{pick_idx, 1'b0} +: 2];
          phase_d = '0;
          level_d = 1'b0;
`ifdef LED_ARB_PREEMPT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_SERVE: begin
        if (tick && mode_q[1]) begin
          if (phase_inc == half) begin
            phase_d = '0;
            level_d = ~level_q;
          end else begin
            phase_d = phase_inc;
          end
        end
        leave_serve = ~req[owner_q];
`ifdef LED_ARB_PREEMPT_EN
        if (tick && (hold_q != HW'(HOLD_TICKS))) hold_d = hold_q + HW'(1);
        if ((hold_d == HW'(HOLD_TICKS)) && other_req) leave_serve = 1'b1;
`endif
        if (leave_serve) begin
          state_d = ST_GAP;
          // A tick in the exit cycle already counts toward the gap.
          gap_d   = tick ? GW'(1) : '0;
        end
      end
      ST_GAP: begin
        if (tick) gap_d = gap_q + GW'(1);
        if (gap_d >= GW'(GAP_TICKS)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    grant_d = '0;
    led_d   = 1'b0;
    if (state_d == ST_SERVE) begin
      grant_d[owner_d] = 1'b1;
      case (mode_d)
        2'd0:    led_d = 1'b0;
        2'd1:    led_d = 1'b1;
        default: led_d = ~level_d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      state_q <= ST_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      owner_q <= '0;
      mode_q  <= '0;
      phase_q <= '0;
      level_q <= 1'b0;
      gap_q   <= '0;
      grant_q <= '0;
      led_q   <= 1'b0;
`ifdef LED_ARB_PREEMPT_EN
      hold_q  <= '0;
`endif
    end else begin
      div_q   <= tick ? '0 : div_q + DW'(1);
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      level_q <= level_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      led_q   <= led_d;
`ifdef LED_ARB_PREEMPT_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with small tick/gap/hold constants; expectations go through exp_q.
module tb_led_arbiter;

  localparam int N_REQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] mode;
  logic [3:0] grant;
  logic       led;
  logic [1:0] state_dbg;

  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  led_arbiter #(
    .N_REQ(N_REQ), .TICK_DIV(4), .SLOW_HALF(4), .FAST_HALF(1), .GAP_TICKS(2), .HOLD_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .grant(grant), .led(led), .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  function automatic logic [15:0] gl();
    return {11'd0, grant, led};
  endfunction

  function automatic logic [15:0] in_range(input int n, input int lo, input int hi);
    return (n >= lo && n <= hi) ? 16'd1 : 16'd0;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input int info);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%0h with no queued expectation", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h (count=%0d)", tag, obs, exp, info);
      end
    end
  endtask

  // Counts consecutive samples equal to {grant,led}=v, bounded by max.
  task automatic count_while(input logic [4:0] v, input int max, output int n);
    n = 0;
    while (n < max && {grant, led} === v) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    req = '0;
    cyc(1);
    push(16'd0);
    check_val("reset_out", gl(), 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [5:0] rnd;
    rst  = 1'b1;
    req  = '0;
    mode = '0;
    cyc(3);
    push(16'd0);
    check_val("reset_state", gl(), 0);
    rst = 1'b0;
    cyc(6);
    push(16'd0);
    check_val("idle_no_req", gl(), 0);

    // Solid pattern, other requesters' modes random.
    rnd  = 6'($urandom_range(0, 63));
    mode = {rnd, 2'b01};
    push({11'd0, 4'b0001, 1'b1});
    req = 4'b0001;
    cyc(1);
    check_val("solid_grant", gl(), 0);
    count_while(5'b00011, 20, n);
    push(16'd20);
    check_val("solid_hold", 16'(n), n);
    push(16'd0);
    req = '0;
    cyc(1);
    check_val("solid_release", gl(), 0);
    cyc(12);

    // Slow blink; mode switched to fast mid-serve must be ignored.
    mode = 8'h02;
    push({11'd0, 4'b0001, 1'b1});
    req = 4'b0001;
    cyc(1);
    check_val("blink_grant", gl(), 0);
    count_while(5'b00011, 40, n);
    push(16'd1);
    check_val("blink_first_half", in_range(n, 13, 16), n);
    mode = 8'h03;
    count_while(5'b00010, 40, n);
    push(16'd16);
    check_val("blink_low1", 16'(n), n);
    count_while(5'b00011, 40, n);
    push(16'd16);
    check_val("blink_high", 16'(n), n);
    count_while(5'b00010, 40, n);
    push(16'd16);
    check_val("blink_low2", 16'(n), n);
    req = '0;
    cyc(12);

    // Round robin and gap length.
    reset_pulse();
    mode = 8'h10;
    req  = 4'b0110;
    push({11'd0, 4'b0010, 1'b0});
    cyc(1);
    check_val("rr_first", gl(), 0);
    cyc(4);
    push({11'd0, 4'b0010, 1'b0});
    check_val("rr_hold_off", gl(), 0);
    req = 4'b0100;
    push(16'd0);
    cyc(1);
    check_val("drop_gap", gl(), 0);
    count_while(5'b00000, 12, n);
    push(16'd1);
    check_val("gap_len", in_range(n, 5, 8), n);
    push({11'd0, 4'b0100, 1'b1});
    check_val("rr_next", gl(), 0);
    req = '0;
    cyc(12);

    // Two constant requesters.
    reset_pulse();
    mode = 8'h41;
    req  = 4'b1001;
    push({11'd0, 4'b0001, 1'b1});
    cyc(1);
    check_val("pre_first", gl(), 0);
`ifdef LED_ARB_PREEMPT_EN
    count_while(5'b00011, 40, n);
    push(16'd1);
    check_val("pre_own0", in_range(n, 29, 32), n);
    count_while(5'b00000, 12, n);
    push(16'd1);
    check_val("pre_gap0", in_range(n, 5, 8), n);
    push({11'd0, 4'b1000, 1'b1});
    check_val("pre_owner3", gl(), 0);
    count_while(5'b10001, 40, n);
    push(16'd1);
    check_val("pre_own3", in_range(n, 29, 32), n);
    count_while(5'b00000, 12, n);
    push(16'd1);
    check_val("pre_gap3", in_range(n, 5, 8), n);
    push({11'd0, 4'b0001, 1'b1});
    check_val("pre_back0", gl(), 0);
`else
    count_while(5'b00011, 1000, n);
    push(16'd1000);
    check_val("no_preempt_hold", 16'(n), n);
`endif
    req = '0;
    cyc(12);

    // Reset mid-blink and mid-gap with requester 3 held.
    reset_pulse();
    mode = 8'h80;
    req  = 4'b1000;
    push({11'd0, 4'b1000, 1'b1});
    cyc(1);
    check_val("r3_grant", gl(), 0);
    cyc(20);
    rst = 1'b1;
    push(16'd0);
    cyc(1);
    check_val("rst_blink", gl(), 0);
    rst = 1'b0;
    push({11'd0, 4'b1000, 1'b1});
    cyc(1);
    check_val("rst_blink_regrant", gl(), 0);
    cyc(3);
    req = '0;
    cyc(1);
    req = 4'b1000;
    push(16'd0);
    cyc(1);
    check_val("in_gap", gl(), 0);
    rst = 1'b1;
    push(16'd0);
    cyc(1);
    check_val("rst_gap", gl(), 0);
    rst = 1'b0;
    push({11'd0, 4'b1000, 1'b1});
    cyc(1);
    check_val("rst_gap_regrant", gl(), 0);
    req = '0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
